// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by the fetcher and the SLB.
// Define MEMCTRL_IO_BUF_FULL_EN to hold IO stores while the IO buffer is full.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
`ifdef MEMCTRL_IO_BUF_FULL_EN
  input  logic              in_io_buffer_full,
`endif
  input  logic              in_fetcher_get_instr,
  input  logic [ADDR_W-1:0] in_fetcher_pc,
  output logic              out_fetcher_get_instr,
  output logic [31:0]       out_fetcher_instr,
  input  logic              in_slb_load,
  input  logic              in_slb_store,
  input  logic [ADDR_W-1:0] in_slb_addr,
  input  logic [1:0]        in_slb_size,
  input  logic [31:0]       in_slb_data,
  output logic              out_slb_done,
  output logic [31:0]       out_slb_data,
  input  logic              in_misbranch,
  input  logic [7:0]        in_ram_data,
  output logic [ADDR_W-1:0] out_ram_a,
  output logic [7:0]        out_ram_dout,
  output logic              out_ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state, state_n;
  logic              pend_f, pend_f_n;
  logic [ADDR_W-1:0] pf_addr, pf_addr_n;
  logic              pend_s, pend_s_n;
  logic              ps_wr, ps_wr_n;
  logic [ADDR_W-1:0] ps_addr, ps_addr_n;
  logic [1:0]        ps_size, ps_size_n;
  logic [31:0]       ps_data, ps_data_n;
  logic              own_s, own_s_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [2:0]        cnt, cnt_n;
  logic [2:0]        num, num_n;
  logic [31:0]       wdata, wdata_n;
  logic [31:0]       res, res_n;
  logic [ADDR_W-1:0] ram_a_n;
  logic [7:0]        ram_dout_n;
  logic              ram_wr_n;
  logic              f_done_n, s_done_n;
  logic [31:0]       f_instr_n, s_data_n;
  logic              s_req, f_req, hold_s;
  logic [1:0]        cm1;
  logic [2:0]        cp1;

  assign cm1   = 2'(cnt - 3'd1);
  assign cp1   = cnt + 3'd1;
  assign s_req = in_slb_store | (in_slb_load & ~in_misbranch);
  assign f_req = in_fetcher_get_instr & ~in_misbranch;

  function automatic logic [2:0] size_to_num(input logic [1:0] s);
    logic [2:0] n;
    unique case (1'b1)
      s == 2'b00: n = 3'd1;
      s == 2'b01: n = 3'd2;
      default:    n = 3'd4;
    endcase
    return n;
  endfunction

  always_comb begin
    state_n    = state;
    pend_f_n   = pend_f;
    pf_addr_n  = pf_addr;
    pend_s_n   = pend_s;
    ps_wr_n    = ps_wr;
    ps_addr_n  = ps_addr;
    ps_size_n  = ps_size;
    ps_data_n  = ps_data;
    own_s_n    = own_s;
    base_n     = base;
    cnt_n      = cnt;
    num_n      = num;
    wdata_n    = wdata;
    res_n      = res;
    ram_a_n    = out_ram_a;
    ram_dout_n = out_ram_dout;
    ram_wr_n   = out_ram_wr;
    f_done_n   = 1'b0;
    s_done_n   = 1'b0;
    f_instr_n  = out_fetcher_instr;
    s_data_n   = out_slb_data;
    hold_s     = 1'b0;

    // A flush drops speculative reads; a pending store survives it.
    if (in_misbranch) begin
      pend_f_n = 1'b0;
      if (!ps_wr) pend_s_n = 1'b0;
    end
    if (s_req) begin
      pend_s_n  = 1'b1;
      ps_wr_n   = in_slb_store;
      ps_addr_n = in_slb_addr;
      ps_size_n = in_slb_size;
      ps_data_n = in_slb_data;
    end
    if (f_req) begin
      pend_f_n  = 1'b1;
      pf_addr_n = in_fetcher_pc;
    end

`ifdef MEMCTRL_IO_BUF_FULL_EN
    hold_s = in_io_buffer_full && ps_wr_n &&
             (ps_addr_n == ADDR_W'(32'h30000) ||
              ps_addr_n == ADDR_W'(32'h30004));
`endif

    unique case (state)
      IDLE: begin
        if (pend_s_n && !hold_s) begin
          pend_s_n = 1'b0;
          own_s_n  = 1'b1;
          base_n   = ps_addr_n;
          num_n    = size_to_num(ps_size_n);
          cnt_n    = 3'd0;
          res_n    = 32'd0;
          ram_a_n  = ps_addr_n;
          if (ps_wr_n) begin
            state_n    = WRITE;
            wdata_n    = ps_data_n;
            ram_dout_n = ps_data_n[7:0];
            ram_wr_n   = 1'b1;
          end else begin
            state_n  = READ;
            ram_wr_n = 1'b0;
          end
        end else if (pend_f_n && !pend_s_n) begin
          pend_f_n = 1'b0;
          own_s_n  = 1'b0;
          base_n   = pf_addr_n;
          num_n    = 3'd4;
          cnt_n    = 3'd0;
          res_n    = 32'd0;
          ram_a_n  = pf_addr_n;
          ram_wr_n = 1'b0;
          state_n  = READ;
        end
      end
      READ: begin
        if (in_misbranch) begin
          state_n = IDLE;
        end else begin
          // RAM returns the byte addressed in the previous cycle.
          if (cnt != 3'd0)
            res_n = res | ({24'd0, in_ram_data} << {cm1, 3'b000});
          if (cnt == num) begin
            state_n = IDLE;
            if (own_s) begin
              s_done_n = 1'b1;
              s_data_n = res_n;
            end else begin
              f_done_n  = 1'b1;
              f_instr_n = res_n;
            end
          end else begin
            cnt_n = cp1;
            if (cp1 != num) ram_a_n = base + ADDR_W'(cp1);
          end
        end
      end
      WRITE: begin
        if (cp1 == num) begin
          state_n  = IDLE;
          ram_wr_n = 1'b0;
          s_done_n = 1'b1;
        end else begin
          cnt_n      = cp1;
          ram_a_n    = base + ADDR_W'(cp1);
          ram_dout_n = 8'(wdata >> {cp1[1:0], 3'b000});
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      pend_f                <= 1'b0;
      pf_addr               <= '0;
      pend_s                <= 1'b0;
      ps_wr                 <= 1'b0;
      ps_addr               <= '0;
      ps_size               <= 2'd0;
      ps_data               <= 32'd0;
      own_s                 <= 1'b0;
      base                  <= '0;
      cnt                   <= 3'd0;
      num                   <= 3'd0;
      wdata                 <= 32'd0;
      res                   <= 32'd0;
      out_ram_a             <= '0;
      out_ram_dout          <= 8'd0;
      out_ram_wr            <= 1'b0;
      out_fetcher_get_instr <= 1'b0;
      out_fetcher_instr     <= 32'd0;
      out_slb_done          <= 1'b0;
      out_slb_data          <= 32'd0;
    end else if (rdy) begin
      state                 <= state_n;
      pend_f                <= pend_f_n;
      pf_addr               <= pf_addr_n;
      pend_s                <= pend_s_n;
      ps_wr                 <= ps_wr_n;
      ps_addr               <= ps_addr_n;
      ps_size               <= ps_size_n;
      ps_data               <= ps_data_n;
      own_s                 <= own_s_n;
      base                  <= base_n;
      cnt                   <= cnt_n;
      num                   <= num_n;
      wdata                 <= wdata_n;
      res                   <= res_n;
      out_ram_a             <= ram_a_n;
      out_ram_dout          <= ram_dout_n;
      out_ram_wr            <= ram_wr_n;
      out_fetcher_get_instr <= f_done_n;
      out_fetcher_instr     <= f_instr_n;
      out_slb_done          <= s_done_n;
      out_slb_data          <= s_data_n;
    end else begin
      // Stalled: everything holds, but done pulses must not repeat.
      out_fetcher_get_instr <= 1'b0;
      out_slb_done          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for mem_ctrl.
// A byte RAM model with one-cycle read latency feeds in_ram_data.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_fetcher_get_instr;
  logic [31:0] in_fetcher_pc;
  logic        out_fetcher_get_instr;
  logic [31:0] out_fetcher_instr;
  logic        in_slb_load, in_slb_store;
  logic [31:0] in_slb_addr;
  logic [1:0]  in_slb_size;
  logic [31:0] in_slb_data;
  logic        out_slb_done;
  logic [31:0] out_slb_data;
  logic        in_misbranch;
  logic [7:0]  in_ram_data;
  logic [31:0] out_ram_a;
  logic [7:0]  out_ram_dout;
  logic        out_ram_wr;
`ifdef MEMCTRL_IO_BUF_FULL_EN
  logic        in_io_buffer_full;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          t0, t1;
  logic        acc;
  logic [31:0] wd;
  logic [31:0] exp_f[$];
  logic [31:0] exp_s[$];
  logic [7:0]  mem [0:511];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
`ifdef MEMCTRL_IO_BUF_FULL_EN
    .in_io_buffer_full     (in_io_buffer_full),
`endif
    .in_fetcher_get_instr  (in_fetcher_get_instr),
    .in_fetcher_pc         (in_fetcher_pc),
    .out_fetcher_get_instr (out_fetcher_get_instr),
    .out_fetcher_instr     (out_fetcher_instr),
    .in_slb_load           (in_slb_load),
    .in_slb_store          (in_slb_store),
    .in_slb_addr           (in_slb_addr),
    .in_slb_size           (in_slb_size),
    .in_slb_data           (in_slb_data),
    .out_slb_done          (out_slb_done),
    .out_slb_data          (out_slb_data),
    .in_misbranch          (in_misbranch),
    .in_ram_data           (in_ram_data),
    .out_ram_a             (out_ram_a),
    .out_ram_dout          (out_ram_dout),
    .out_ram_wr            (out_ram_wr)
  );

  // Sparse RAM: every address the bench touches maps to a distinct key.
  function automatic logic [8:0] key(input logic [31:0] a);
    return {a[17:12], a[2:0]};
  endfunction

  function automatic logic [7:0] init_byte(input int k);
    case (k)
      8:       return 8'h13;
      9:       return 8'h05;
      10:      return 8'h10;
      11:      return 8'h00;
      16:      return 8'h11;
      17:      return 8'h22;
      18:      return 8'hFE;
      19:      return 8'hFF;
      510:     return 8'h01;
      511:     return 8'h02;
      0:       return 8'h03;
      1:       return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_byte(i);
    end else if (rdy && out_ram_wr) begin
      mem[key(out_ram_a)] <= out_ram_dout;
    end
    if (rdy) in_ram_data <= mem[key(out_ram_a)];
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    in_fetcher_get_instr = 1'b0;
    in_slb_load          = 1'b0;
    in_slb_store         = 1'b0;
    in_misbranch         = 1'b0;
  endtask

  task automatic req_fetch(input logic [31:0] pc);
    in_fetcher_get_instr = 1'b1;
    in_fetcher_pc        = pc;
    step();
    in_fetcher_get_instr = 1'b0;
  endtask

  task automatic req_slb(input bit st, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] d);
    in_slb_store = st;
    in_slb_load  = !st;
    in_slb_addr  = a;
    in_slb_size  = sz;
    in_slb_data  = d;
    step();
    in_slb_store = 1'b0;
    in_slb_load  = 1'b0;
  endtask

  task automatic wait_done(input bit slb, input bit has_data,
                           input int exp_cyc, input string tag);
    int          seen;
    logic [31:0] e;
    seen = -1;
    for (int i = 0; i < 40 && seen < 0; i++) begin
      if (slb ? out_slb_done : out_fetcher_get_instr) seen = cyc;
      else step();
    end
    chk({tag, "_cycle"}, 32'(seen), 32'(exp_cyc));
    if (seen >= 0 && has_data) begin
      if (slb) e = exp_s.pop_front();
      else     e = exp_f.pop_front();
      chk({tag, "_data"}, slb ? out_slb_data : out_fetcher_instr, e);
    end
    if (seen >= 0) begin
      step();
      chk({tag, "_pulse"},
          {31'd0, slb ? out_slb_done : out_fetcher_get_instr}, 32'd0);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      hit = hit | out_slb_done | out_fetcher_get_instr;
      step();
    end
    chk(tag, {31'd0, hit}, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    rdy           = 1'b1;
    in_fetcher_pc = 32'd0;
    in_slb_addr   = 32'd0;
    in_slb_size   = 2'd0;
    in_slb_data   = 32'd0;
    clr();
`ifdef MEMCTRL_IO_BUF_FULL_EN
    in_io_buffer_full = 1'b0;
`endif
    step();
    step();
    chk("rst_wr", {31'd0, out_ram_wr}, 32'd0);
    chk("rst_a", out_ram_a, 32'd0);
    chk("rst_dout", {24'd0, out_ram_dout}, 32'd0);
    chk("rst_fdone", {31'd0, out_fetcher_get_instr}, 32'd0);
    chk("rst_sdone", {31'd0, out_slb_done}, 32'd0);
    chk("rst_instr", out_fetcher_instr, 32'd0);
    chk("rst_sdata", out_slb_data, 32'd0);
    rst = 1'b0;
    step();

    t0 = cyc;
    exp_f.push_back(32'h00100513);
    req_fetch(32'h1000);
    chk("f_addr0", out_ram_a, 32'h1000);
    wait_done(1'b0, 1'b1, t0 + 6, "fetch");

    t0 = cyc;
    exp_s.push_back(32'h0000FFFE);
    exp_f.push_back(32'h00100513);
    in_slb_load          = 1'b1;
    in_slb_addr          = 32'h2002;
    in_slb_size          = 2'b01;
    in_fetcher_get_instr = 1'b1;
    in_fetcher_pc        = 32'h1000;
    step();
    clr();
    wait_done(1'b1, 1'b1, t0 + 4, "ld2");
    wait_done(1'b0, 1'b1, t0 + 10, "ld2_fetch");

    t0 = cyc;
    wd = 32'hDEADBEEF;
    req_slb(1'b1, 32'h3000, 2'b10, wd);
    for (int k = 0; k < 4; k++) begin
      chk("st_wr", {31'd0, out_ram_wr}, 32'd1);
      chk("st_a", out_ram_a, 32'h3000 + 32'(k));
      chk("st_dout", {24'd0, out_ram_dout}, (wd >> (8 * k)) & 32'hFF);
      step();
    end
    chk("st_wr_end", {31'd0, out_ram_wr}, 32'd0);
    wait_done(1'b1, 1'b0, t0 + 5, "st4");

    t0 = cyc;
    exp_s.push_back(32'hDEADBEEF);
    req_slb(1'b0, 32'h3000, 2'b10, 32'd0);
    wait_done(1'b1, 1'b1, t0 + 6, "ld4");

    t0 = cyc;
    req_fetch(32'h1000);
    step();
    step();
    in_misbranch = 1'b1;
    step();
    in_misbranch = 1'b0;
    chk("mb_nodone", {31'd0, out_fetcher_get_instr}, 32'd0);
    t1 = cyc;
    exp_f.push_back(32'hFFFE2211);
    req_fetch(32'h2000);
    wait_done(1'b0, 1'b1, t1 + 6, "mb_fetch");

    req_slb(1'b0, 32'h2002, 2'b01, 32'd0);
    step();
    in_misbranch = 1'b1;
    step();
    in_misbranch = 1'b0;
    quiet(6, "mb_ld_abort");
    in_slb_load  = 1'b1;
    in_slb_addr  = 32'h1000;
    in_slb_size  = 2'b00;
    in_misbranch = 1'b1;
    step();
    clr();
    quiet(5, "mb_ld_drop");

    t0 = cyc;
    in_slb_store = 1'b1;
    in_slb_addr  = 32'h30000;
    in_slb_size  = 2'b00;
    in_slb_data  = 32'h1234565A;
    in_misbranch = 1'b1;
    step();
    in_slb_store = 1'b0;
    chk("mbst_wr", {31'd0, out_ram_wr}, 32'd1);
    chk("mbst_a", out_ram_a, 32'h30000);
    chk("mbst_dout", {24'd0, out_ram_dout}, 32'h5A);
    step();
    in_misbranch = 1'b0;
    wait_done(1'b1, 1'b0, t0 + 2, "st1_mb");

    t0 = cyc;
    exp_s.push_back(32'h04030201);
    req_slb(1'b0, 32'hFFFFFFFE, 2'b10, 32'd0);
    wait_done(1'b1, 1'b1, t0 + 6, "wrap");

    t0 = cyc;
    exp_s.push_back(32'h00000005);
    req_slb(1'b0, 32'h1001, 2'b00, 32'd0);
    wait_done(1'b1, 1'b1, t0 + 3, "ld1");

    t0 = cyc;
    exp_f.push_back(32'h00100513);
    req_fetch(32'h1000);
    step();
    rdy = 1'b0;
    step();
    step();
    step();
    rdy = 1'b1;
    wait_done(1'b0, 1'b1, t0 + 9, "stall");

`ifdef MEMCTRL_IO_BUF_FULL_EN
    t0 = cyc;
    in_io_buffer_full    = 1'b1;
    exp_f.push_back(32'h00100513);
    in_slb_store         = 1'b1;
    in_slb_addr          = 32'h30004;
    in_slb_size          = 2'b00;
    in_slb_data          = 32'h77;
    in_fetcher_get_instr = 1'b1;
    in_fetcher_pc        = 32'h1000;
    step();
    clr();
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | out_ram_wr | out_fetcher_get_instr;
      step();
    end
    acc = acc | out_ram_wr;
    chk("io_hold", {31'd0, acc}, 32'd0);
    in_io_buffer_full = 1'b0;
    step();
    chk("io_wr", {31'd0, out_ram_wr}, 32'd1);
    chk("io_a", out_ram_a, 32'h30004);
    chk("io_dout", {24'd0, out_ram_dout}, 32'h77);
    wait_done(1'b1, 1'b0, t0 + 7, "io_st");
    wait_done(1'b0, 1'b1, t0 + 13, "io_fetch");
`endif

    req_slb(1'b1, 32'h4000, 2'b10, 32'hCAFEF00D);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_wr", {31'd0, out_ram_wr}, 32'd0);
    chk("mrst_a", out_ram_a, 32'd0);
    chk("mrst_dout", {24'd0, out_ram_dout}, 32'd0);
    chk("mrst_sdone", {31'd0, out_slb_done}, 32'd0);
    chk("mrst_fdone", {31'd0, out_fetcher_get_instr}, 32'd0);
    quiet(6, "mrst_nodone");

    t0 = cyc;
    exp_f.push_back(32'h00100513);
    req_fetch(32'h1000);
    wait_done(1'b0, 1'b1, t0 + 6, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the byte-wide RAM port and the two memory clients: the instruction fetcher and the store/load buffer (SLB). Latches single-cycle request pulses, serialises each access into 1/2/4 byte-by-byte RAM cycles, and assembles or splits words little-endian. Returns a single-cycle done pulse with data. Misbranch flushes abort speculative reads; stores always complete.

## Interface
- ADDR_W, 32, address width; all address ports are this wide.
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high; one clock.
- rdy  input  1  global enable; low freezes all registers.
- in_fetcher_get_instr  input  1  one-cycle fetch request pulse.
- in_fetcher_pc  input  32  fetch address, valid with the pulse.
- out_fetcher_get_instr  output  1  one-cycle pulse: instruction valid.
- out_fetcher_instr  output  32  fetched word.
- in_slb_load / in_slb_store  input  1  one-cycle request pulses; never both high together.
- in_slb_addr  input  32  data address.
- in_slb_size  input  2  byte count code: 00=1, 01=2, 10=4.
- in_slb_data  input  32  store data; low bytes used.
- out_slb_done  output  1  one-cycle pulse: load data valid or store finished.
- out_slb_data  output  32  load data, zero-extended; SLB sign-extends.
- in_misbranch  input  1  flush.
- in_ram_data  input  8  RAM read byte.
- out_ram_a  output  32  RAM byte address.
- out_ram_dout  output  8  RAM write byte.
- out_ram_wr  output  1  1 = write, 0 = read.

## Operation
- Reset: all outputs 0; state IDLE; both pending flags cleared.
- Pending latches: fetch and SLB pulses set pending_f / pending_s with address, size, data and direction. Each is cleared when its access is issued.
- States: IDLE, READ, WRITE.
- IDLE: if pending_s, start the SLB access. Otherwise, if pending_f, start a 4-byte fetch. SLB has priority.
- Starting an access sets byte counter cnt=0 and total N (fetch is always 4). It drives out_ram_a=addr, and for a write also drives out_ram_dout=byte0 and out_ram_wr=1.
- READ: out_ram_a advances addr+1 … addr+N-1 on successive cycles. Byte k is sampled one cycle after its address into result[8k+7:8k]. After byte N-1 is sampled, the block pulses done to the owning client for one cycle and returns to IDLE. Unused high bytes are 0.
- WRITE: byte k is driven for one cycle with out_ram_wr=1. After byte N-1, out_ram_wr=0, out_slb_done pulses, and the state returns to IDLE.
- out_ram_wr is 0 whenever the block is not driving a write byte.
- Address arithmetic is modulo 2^32. An access crossing 0xFFFFFFFF wraps to 0.
- in_misbranch in any cycle:
  - clears pending_f and any pending load;
  - aborts an in-flight READ (fetch or load): no done pulse, IDLE next cycle;
  - never affects a pending or in-flight store, which completes and pulses out_slb_done.
- A new request pulse arriving while that client is already pending or in flight is a protocol error. Clients never issue one.
- A request pulse in the same cycle as in_misbranch: a load or fetch is dropped; a store is latched.
- rst mid-access aborts it immediately, with no done pulse and out_ram_wr=0 next cycle.

## Timing
- All outputs are registered.
- Request pulse sampled in cycle 0 with the controller idle: first address is driven in cycle 1.
- Read of N bytes: done pulse in cycle N+2. A fetch completes in cycle 6.
- Write of N bytes: bytes are driven in cycles 1..N; out_slb_done pulses in cycle N+1.
- Back-to-back: the next access may start in the cycle after done.
- Cycles with rdy=0 do not count. State and outputs hold, except done pulses, which are not repeated.

## Configuration
- MEMCTRL_IO_BUF_FULL_EN defined:
  - adds port in_io_buffer_full (input, 1 bit);
  - a store to 0x30000 or 0x30004 is not started from IDLE while in_io_buffer_full=1; it stays pending;
  - fetches do not overtake it;
  - a store already in flight is unaffected.
- MEMCTRL_IO_BUF_FULL_EN undefined: no port; stores start as soon as they are selected.

## Test plan
- Fetch at pc=0x1000 with RAM bytes 0x13,0x05,0x10,0x00 -> out_fetcher_get_instr high in cycle 6 only, out_fetcher_instr=0x00100513.
- SLB 2-byte load at 0x2002 (RAM 0xFE,0xFF) and fetch pulsed in the same cycle -> load served first: out_slb_data=0x0000FFFE in cycle 4; fetch done in cycle 10.
- 4-byte store of 0xDEADBEEF at 0x3000 -> out_ram_wr=1 in cycles 1-4 with addresses 0x3000-0x3003 and bytes EF,BE,AD,DE; out_slb_done in cycle 5; out_ram_wr=0 in cycle 5.
- in_misbranch in cycle 3 of a fetch -> no out_fetcher_get_instr; IDLE in cycle 4; a new fetch at 0x2000 in cycle 4 returns correct data in cycle 10.
- in_misbranch during a 1-byte store to 0x30000 -> store completes, out_slb_done in cycle 2. With MEMCTRL_IO_BUF_FULL_EN and in_io_buffer_full=1 held 5 cycles, out_ram_wr stays 0 until it drops.
- rst asserted in cycle 2 of a store -> out_ram_wr=0 and all outputs 0 next cycle; no done pulse.
